// File: rtl/prio_scan_pkg.sv
// prio_scan_pkg: shared types and helpers for the prio_scan_encoder block.
//   state_e   : FSM state encoding (IDLE, SCAN)
//   idx_width : index width derived from the request vector width
package prio_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Index width for a WIDTH-bit vector; never below one bit.
  function automatic int idx_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/prio_scan_encoder_if.sv
// prio_scan_encoder_if: request-in / index-out handshake bundle.
//   in_vec, in_valid, in_ready            : request vector channel
//   out_idx, out_valid, out_ready, out_last : index channel
// Valid/ready semantics on both channels: a transfer happens on a rising
// edge where valid && ready are both high; the producer holds its payload
// and valid stable until that transfer; ready may depend on valid.
// Modports: master = the environment, slave = the encoder.
interface prio_scan_encoder_if
  import prio_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
);

  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last
  );

endinterface

// File: rtl/prio_ffs.sv
// prio_ffs: combinational find-first-set over a WIDTH-bit vector.
//   vec_i    : vector to search
//   idx_o    : index of the first set bit in the chosen direction (0 if none)
//   onehot_o : one-hot mask of that bit (all zero if none)
// MSB_FIRST=1 picks the highest set bit, MSB_FIRST=0 the lowest.
module prio_ffs #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] onehot_o
);

  // The loop runs toward the preferred end so the last hit wins.
  generate
    if (MSB_FIRST) begin : g_msb
      always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (vec_i[i]) begin
            idx_o       = IDX_W'(i);
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
          end
        end
      end
    end else begin : g_lsb
      always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (vec_i[i]) begin
            idx_o       = IDX_W'(i);
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: sequential priority encoder. Accepts a WIDTH-bit
// request vector and emits the index of every set bit, one per output
// handshake, highest index first (lowest first when the optional macro
// PRIO_SCAN_LSB_FIRST_EN is defined).
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : prio_scan_encoder_if.slave (in_* request, out_* index channel)
//   state_o : debug view of the FSM state
module prio_scan_encoder
  import prio_scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  prio_scan_encoder_if.slave        bus,
  output state_e                    state_o
);

  localparam int IDX_W = idx_width(WIDTH);

`ifdef PRIO_SCAN_LSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b0;
`else
  localparam bit MSB_FIRST = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [IDX_W-1:0] ffs_idx;
  logic [WIDTH-1:0] ffs_mask;
  logic             out_valid_w;
  logic             single_w;
  logic             out_fire;
  logic             in_ready_w;
  logic             in_fire;

  prio_ffs #(
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .vec_i    (pend_q),
    .idx_o    (ffs_idx),
    .onehot_o (ffs_mask)
  );

  // Outputs come only from registered pend, never from in_vec.
  assign out_valid_w = (state_q == SCAN);
  assign single_w    = ((pend_q & (pend_q - WIDTH'(1))) == '0);

  assign bus.out_valid = out_valid_w;
  assign bus.out_idx   = out_valid_w ? ffs_idx : '0;
  assign bus.out_last  = out_valid_w & single_w;

  // The final output handshake reopens the input in the same cycle so a
  // waiting vector follows with no bubble (out_ready -> in_ready is
  // deliberately combinational).
  assign out_fire   = out_valid_w & bus.out_ready;
  assign in_ready_w = !rst && ((state_q == IDLE) || (out_fire && single_w));
  assign in_fire    = bus.in_valid & in_ready_w;

  assign bus.in_ready = in_ready_w;
  assign state_o      = state_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (out_fire) begin
      pend_d = pend_q & ~ffs_mask;
      if (single_w) state_d = IDLE;
    end
    // An all-zero vector is consumed but leaves the FSM idle.
    if (in_fire) begin
      if (bus.in_vec != '0) begin
        pend_d  = bus.in_vec;
        state_d = SCAN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb_prio_scan_encoder: directed bench for prio_scan_encoder.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Expected {last, idx} pairs go into exp_q and are popped on
// every observed output handshake.
module tb_prio_scan_encoder;
  import prio_scan_pkg::*;

`ifdef PRIO_SCAN_LSB_FIRST_EN
  localparam int WIDTH = 16;
`else
  localparam int WIDTH = 8;
`endif
  localparam int IDX_W = idx_width(WIDTH);
  localparam int W     = IDX_W + 1;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  prio_scan_encoder_if #(.WIDTH(WIDTH)) bus ();

  prio_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted index must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_output", 32'(bus.out_valid), 32'd0);
      end else begin
        check("sb_idx_last", 32'({bus.out_last, bus.out_idx}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [WIDTH-1:0] vec, input logic valid);
    bus.in_vec   = vec;
    bus.in_valid = valid;
  endtask

  task automatic expect_out(input logic last, input int idx);
    exp_q.push_back({last, IDX_W'(idx)});
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.in_vec    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    sample();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    tick();
    rst = 1'b0;
    sample();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

`ifdef PRIO_SCAN_LSB_FIRST_EN
    // 16'h8001 lowest first: 0 then 15 (last)
    tick();
    bus.out_ready = 1'b1;
    drive_in(16'h8001, 1'b1);
    expect_out(1'b0, 0);
    expect_out(1'b1, 15);
    tick();
    drive_in('0, 1'b0);
    sample();
    check("lsb_first_idx", 32'(bus.out_idx), 32'd0);
    tick();
    sample();
    check("lsb_last_idx", 32'(bus.out_idx), 32'd15);
    check("lsb_last_flag", 32'(bus.out_last), 32'd1);
    tick();
    sample();
    check("lsb_done_valid", 32'(bus.out_valid), 32'd0);

    // 16'h00A5 lowest first: 0,2,5,7
    drive_in(16'h00A5, 1'b1);
    expect_out(1'b0, 0);
    expect_out(1'b0, 2);
    expect_out(1'b0, 5);
    expect_out(1'b1, 7);
    tick();
    drive_in('0, 1'b0);
    repeat (4) tick();
    sample();
    check("lsb_a5_done_valid", 32'(bus.out_valid), 32'd0);
`else
    // Test 1: 8'b1010_0101 -> 7,5,2,0 on consecutive cycles
    tick();
    bus.out_ready = 1'b1;
    drive_in(8'hA5, 1'b1);
    expect_out(1'b0, 7);
    expect_out(1'b0, 5);
    expect_out(1'b0, 2);
    expect_out(1'b1, 0);
    sample();
    check("t1_in_ready_idle", 32'(bus.in_ready), 32'd1);
    check("t1_out_valid_idle", 32'(bus.out_valid), 32'd0);
    tick();
    drive_in('0, 1'b0);
    sample();
    check("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check("t1_first_idx", 32'(bus.out_idx), 32'd7);
    check("t1_first_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    sample();
    check("t1_second_idx", 32'(bus.out_idx), 32'd5);
    tick();
    sample();
    check("t1_third_last", 32'(bus.out_last), 32'd0);
    tick();
    sample();
    check("t1_final_idx", 32'(bus.out_idx), 32'd0);
    check("t1_final_last", 32'(bus.out_last), 32'd1);
    check("t1_final_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    sample();
    check("t1_done_valid", 32'(bus.out_valid), 32'd0);
    check("t1_done_idx", 32'(bus.out_idx), 32'd0);

    // Test 2: zero vector accepted and dropped
    drive_in(8'h00, 1'b1);
    sample();
    check("t2_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive_in('0, 1'b0);
    sample();
    check("t2_out_valid", 32'(bus.out_valid), 32'd0);
    check("t2_state", 32'(dbg_state), 32'(IDLE));

    // Test 3: 8'h81 with a three-cycle stall; in_vec changes are ignored
    bus.out_ready = 1'b0;
    drive_in(8'h81, 1'b1);
    expect_out(1'b0, 7);
    expect_out(1'b1, 0);
    tick();
    for (int s = 0; s < 3; s++) begin
      drive_in(8'h3C ^ 8'(s), 1'b1);
      sample();
      check($sformatf("t3_stall%0d_valid", s), 32'(bus.out_valid), 32'd1);
      check($sformatf("t3_stall%0d_idx", s), 32'(bus.out_idx), 32'd7);
      check($sformatf("t3_stall%0d_last", s), 32'(bus.out_last), 32'd0);
      check($sformatf("t3_stall%0d_in_ready", s), 32'(bus.in_ready), 32'd0);
      tick();
    end
    drive_in('0, 1'b0);
    bus.out_ready = 1'b1;
    sample();
    check("t3_release_idx", 32'(bus.out_idx), 32'd7);
    tick();
    sample();
    check("t3_second_idx", 32'(bus.out_idx), 32'd0);
    check("t3_second_last", 32'(bus.out_last), 32'd1);
    tick();
    sample();
    check("t3_done_valid", 32'(bus.out_valid), 32'd0);

    // Test 4: back-to-back 8'h02 then 8'h40 with no bubble
    drive_in(8'h02, 1'b1);
    expect_out(1'b1, 1);
    expect_out(1'b1, 6);
    tick();
    drive_in(8'h40, 1'b1);
    sample();
    check("t4_first_idx", 32'(bus.out_idx), 32'd1);
    check("t4_in_ready_on_last", 32'(bus.in_ready), 32'd1);
    tick();
    drive_in('0, 1'b0);
    sample();
    check("t4_second_valid", 32'(bus.out_valid), 32'd1);
    check("t4_second_idx", 32'(bus.out_idx), 32'd6);
    tick();
    sample();
    check("t4_done_valid", 32'(bus.out_valid), 32'd0);

    // Test 5: reset mid-scan of 8'hFF after two outputs
    drive_in(8'hFF, 1'b1);
    expect_out(1'b0, 7);
    expect_out(1'b0, 6);
    tick();
    drive_in('0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    sample();
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    sample();
    check("t5_post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_post_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    sample();
    check("t5_still_idle", 32'(bus.out_valid), 32'd0);
    drive_in(8'h10, 1'b1);
    expect_out(1'b1, 4);
    tick();
    drive_in('0, 1'b0);
    sample();
    check("t5_fresh_idx", 32'(bus.out_idx), 32'd4);
    check("t5_fresh_last", 32'(bus.out_last), 32'd1);
    tick();
    sample();
    check("t5_done_valid", 32'(bus.out_valid), 32'd0);
`endif

    tick();
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
